mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl.sv | 152 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: launches multi-cycle mult/div, owns HI/LO, stalls D.
// Optional MDU_MADD_EN adds SPECIAL2 madd/maddu/msub/msubu accumulate operations.
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  e_opcode,
  input  logic [5:0]  e_func,
  input  logic        e_valid,
  input  logic        e_cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [5:0]  d_opcode,
  input  logic [5:0]  d_func,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi, r_lo;
  logic [31:0]      r_pend_hi, r_pend_lo;
  logic             r_pend_wr;

  logic w_e_special, w_d_special;
  logic w_e_mult, w_e_div, w_e_mfhi, w_e_mflo, w_e_mthi, w_e_mtlo;
  logic w_e_madd, w_d_madd, w_d_md;
  logic w_start, w_go, w_mt_ok, w_signed;

  assign w_e_special = (e_opcode == 6'h00);
  assign w_d_special = (d_opcode == 6'h00);

  assign w_e_mult = w_e_special & ((e_func == 6'h18) | (e_func == 6'h19));
  assign w_e_div  = w_e_special & ((e_func == 6'h1A) | (e_func == 6'h1B));
  assign w_e_mfhi = w_e_special & (e_func == 6'h10);
  assign w_e_mthi = w_e_special & (e_func == 6'h11);
  assign w_e_mflo = w_e_special & (e_func == 6'h12);
  assign w_e_mtlo = w_e_special & (e_func == 6'h13);

`ifdef MDU_MADD_EN
  assign w_e_madd = (e_opcode == 6'h1C) &
                    ((e_func == 6'h00) | (e_func == 6'h01) | (e_func == 6'h04) | (e_func == 6'h05));
  assign w_d_madd = (d_opcode == 6'h1C) &
                    ((d_func == 6'h00) | (d_func == 6'h01) | (d_func == 6'h04) | (d_func == 6'h05));
`else
  assign w_e_madd = 1'b0;
  assign w_d_madd = 1'b0;
`endif

  assign w_d_md = (w_d_special & ((d_func == 6'h10) | (d_func == 6'h11) | (d_func == 6'h12) |
                                  (d_func == 6'h13) | (d_func == 6'h18) | (d_func == 6'h19) |
                                  (d_func == 6'h1A) | (d_func == 6'h1B))) | w_d_madd;

  // Every start-type encoding uses func[0]=1 for the unsigned variant.
  assign w_signed = ~e_func[0];
  assign w_start  = w_e_mult | w_e_div | w_e_madd;
  assign w_mt_ok  = e_valid & ~e_cancel & (r_state == S_IDLE);
  assign w_go     = w_mt_ok & w_start;

  logic [63:0] w_opa, w_opb, w_prod, w_acc;
  assign w_opa  = {(w_signed ? {32{rs_val[31]}} : 32'h0), rs_val};
  assign w_opb  = {(w_signed ? {32{rt_val[31]}} : 32'h0), rt_val};
  assign w_prod = w_opa * w_opb;
  assign w_acc  = e_func[2] ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);

  // Signed divide works on magnitudes; quotient truncates, remainder follows the dividend.
  logic        w_a_neg, w_b_neg, w_div_zero;
  logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_q, w_r;
  assign w_a_neg    = w_signed & rs_val[31];
  assign w_b_neg    = w_signed & rt_val[31];
  assign w_a_mag    = w_a_neg ? (32'h0 - rs_val) : rs_val;
  assign w_b_mag    = w_b_neg ? (32'h0 - rt_val) : rt_val;
  assign w_div_zero = (rt_val == 32'h0);
  assign w_b_safe   = w_div_zero ? 32'h1 : w_b_mag;
  assign w_q_mag    = w_a_mag / w_b_safe;
  assign w_r_mag    = w_a_mag % w_b_safe;
  assign w_q        = (w_a_neg ^ w_b_neg) ? (32'h0 - w_q_mag) : w_q_mag;
  assign w_r        = w_a_neg ? (32'h0 - w_r_mag) : w_r_mag;

  logic [31:0] w_res_hi, w_res_lo;
  logic        w_res_wr;
  always_comb begin
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    w_res_wr = 1'b1;
    if (w_e_div) begin
      w_res_hi = w_r;
      w_res_lo = w_q;
      w_res_wr = ~w_div_zero;
    end else if (w_e_madd) begin
      w_res_hi = w_acc[63:32];
      w_res_lo = w_acc[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= 32'h0;
      r_lo      <= 32'h0;
      r_pend_hi <= 32'h0;
      r_pend_lo <= 32'h0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state   <= S_RUN;
            r_cnt     <= w_e_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
          end else if (w_mt_ok) begin
            if (w_e_mthi) r_hi <= rs_val;
            if (w_e_mtlo) r_lo <= rs_val;
          end
        end
        default: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign busy     = (r_state == S_RUN);
  assign stall    = w_d_md & (busy | w_go);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign md_rdata = w_e_mfhi ? r_hi : (w_e_mflo ? r_lo : 32'h0);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl; covers the MDU_MADD_EN build when that macro is defined.
module tb_mdu_ctrl;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_SPEC2   = 6'h1C;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  e_opcode, e_func, d_opcode, d_func;
  logic        e_valid, e_cancel;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall;
  logic [31:0] hi, lo, md_rdata;

  int checkCount = 0;
  int passCount  = 0;

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .e_opcode(e_opcode), .e_func(e_func), .e_valid(e_valid), .e_cancel(e_cancel),
    .rs_val(rs_val), .rt_val(rt_val),
    .d_opcode(d_opcode), .d_func(d_func),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo), .md_rdata(md_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic cancel,
                               input logic [5:0] eop, input logic [5:0] efn,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [5:0] dop, input logic [5:0] dfn);
    e_valid = valid; e_cancel = cancel;
    e_opcode = eop;  e_func = efn;
    rs_val = rs;     rt_val = rt;
    d_opcode = dop;  d_func = dfn;
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0, 6'h00, 6'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start op with mflo waiting in D; leaves the bench in cycle lat+1 with a bubble in E.
  task automatic startAndWait(input string tag, input logic [5:0] op, input logic [5:0] fn,
                              input logic [31:0] rs, input logic [31:0] rt, input int lat);
    applyStimulus(1'b1, 1'b0, op, fn, rs, rt, OP_SPECIAL, F_MFLO);
    #1;
    checkOutput({tag, " c0 stall"}, {31'h0, stall}, 32'h1);
    checkOutput({tag, " c0 busy"},  {31'h0, busy},  32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0, OP_SPECIAL, F_MFLO);
    for (int c = 1; c <= lat; c++) begin
      checkOutput({tag, " run busy"},  {31'h0, busy},  32'h1);
      checkOutput({tag, " run stall"}, {31'h0, stall}, 32'h1);
      tick();
    end
    checkOutput({tag, " done busy"},  {31'h0, busy},  32'h0);
    checkOutput({tag, " done stall"}, {31'h0, stall}, 32'h0);
    bubble();
  endtask

  initial begin
    reset = 1'b1;
    bubble();
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("reset busy",  {31'h0, busy},  32'h0);
    checkOutput("reset stall", {31'h0, stall}, 32'h0);
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);

    startAndWait("mult", OP_SPECIAL, F_MULT, 32'hFFFFFFFE, 32'h3, 5);
    checkOutput("mult hi", hi, 32'hFFFFFFFF);
    checkOutput("mult lo", lo, 32'hFFFFFFFA);
    applyStimulus(1'b1, 1'b0, OP_SPECIAL, F_MFLO, 32'h0, 32'h0, 6'h00, 6'h00);
    #1 checkOutput("mflo rdata", md_rdata, 32'hFFFFFFFA);
    applyStimulus(1'b1, 1'b0, OP_SPECIAL, F_MFHI, 32'h0, 32'h0, 6'h00, 6'h00);
    #1 checkOutput("mfhi rdata", md_rdata, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b0, OP_SPECIAL, F_ADD, 32'h0, 32'h0, 6'h00, 6'h00);
    #1 checkOutput("non-md rdata", md_rdata, 32'h0);
    tick();

    startAndWait("multu", OP_SPECIAL, F_MULTU, 32'hFFFFFFFE, 32'h3, 5);
    checkOutput("multu hi", hi, 32'h00000002);
    checkOutput("multu lo", lo, 32'hFFFFFFFA);

    startAndWait("div", OP_SPECIAL, F_DIV, 32'hFFFFFFF9, 32'h2, 10);
    checkOutput("div hi", hi, 32'hFFFFFFFF);
    checkOutput("div lo", lo, 32'hFFFFFFFD);

    startAndWait("divu0", OP_SPECIAL, F_DIVU, 32'hFFFFFFF9, 32'h0, 10);
    checkOutput("divu0 hi", hi, 32'hFFFFFFFF);
    checkOutput("divu0 lo", lo, 32'hFFFFFFFD);

    startAndWait("divovf", OP_SPECIAL, F_DIV, 32'h80000000, 32'hFFFFFFFF, 10);
    checkOutput("divovf hi", hi, 32'h0);
    checkOutput("divovf lo", lo, 32'h80000000);

    startAndWait("divneg", OP_SPECIAL, F_DIV, 32'h7, 32'hFFFFFFFE, 10);
    checkOutput("divneg hi", hi, 32'h1);
    checkOutput("divneg lo", lo, 32'hFFFFFFFD);

    startAndWait("divu", OP_SPECIAL, F_DIVU, 32'hFFFFFFF9, 32'h2, 10);
    checkOutput("divu hi", hi, 32'h1);
    checkOutput("divu lo", lo, 32'h7FFFFFFC);

    applyStimulus(1'b1, 1'b0, OP_SPECIAL, F_MTHI, 32'h1234, 32'h0, 6'h00, 6'h00);
    tick();
    applyStimulus(1'b1, 1'b0, OP_SPECIAL, F_MFHI, 32'h0, 32'h0, 6'h00, 6'h00);
    #1 checkOutput("mthi->mfhi", md_rdata, 32'h1234);
    applyStimulus(1'b1, 1'b0, OP_SPECIAL, F_MTLO, 32'h5678, 32'h0, 6'h00, 6'h00);
    tick();
    applyStimulus(1'b1, 1'b0, OP_SPECIAL, F_MFLO, 32'h0, 32'h0, 6'h00, 6'h00);
    #1 checkOutput("mtlo->mflo", md_rdata, 32'h5678);
    checkOutput("mtlo hi kept", hi, 32'h1234);

    applyStimulus(1'b1, 1'b0, OP_SPECIAL, F_MULT, 32'h2, 32'h3, 6'h00, 6'h00);
    tick();
    applyStimulus(1'b1, 1'b0, OP_SPECIAL, F_MTHI, 32'hDEAD, 32'h0, 6'h00, 6'h00);
    tick();
    bubble();
    #1 checkOutput("mthi busy hi", hi, 32'h1234);
    repeat (4) tick();
    checkOutput("busy mult done", {31'h0, busy}, 32'h0);
    checkOutput("busy mult hi", hi, 32'h0);
    checkOutput("busy mult lo", lo, 32'h6);

    applyStimulus(1'b1, 1'b1, OP_SPECIAL, F_MULT, 32'h5, 32'h5, OP_SPECIAL, F_MFLO);
    #1 checkOutput("cancel stall", {31'h0, stall}, 32'h0);
    tick();
    bubble();
    #1 checkOutput("cancel busy", {31'h0, busy}, 32'h0);
    checkOutput("cancel hi", hi, 32'h0);
    checkOutput("cancel lo", lo, 32'h6);

    applyStimulus(1'b1, 1'b0, OP_SPECIAL, F_DIV, 32'd100, 32'd7, 6'h00, 6'h00);
    tick();
    bubble();
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst mid busy", {31'h0, busy}, 32'h0);
    checkOutput("rst mid hi", hi, 32'h0);
    checkOutput("rst mid lo", lo, 32'h0);
    repeat (12) tick();
    checkOutput("rst late hi", hi, 32'h0);
    checkOutput("rst late lo", lo, 32'h0);

    applyStimulus(1'b1, 1'b0, OP_SPECIAL, F_MTLO, 32'hFFFFFFFF, 32'h0, 6'h00, 6'h00);
    tick();
    bubble();
`ifdef MDU_MADD_EN
    startAndWait("madd", OP_SPEC2, 6'h00, 32'h1, 32'h1, 5);
    checkOutput("madd hi", hi, 32'h1);
    checkOutput("madd lo", lo, 32'h0);
`else
    applyStimulus(1'b1, 1'b0, OP_SPEC2, 6'h00, 32'h1, 32'h1, OP_SPEC2, 6'h00);
    #1 checkOutput("madd off stall", {31'h0, stall}, 32'h0);
    tick();
    bubble();
    #1 checkOutput("madd off busy", {31'h0, busy}, 32'h0);
    repeat (6) tick();
    checkOutput("madd off hi", hi, 32'h0);
    checkOutput("madd off lo", lo, 32'hFFFFFFFF);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
